aes_round_key_sched: RTL and testbench

//   Iterative AES-128 key-schedule controller for the encrypt datapath.

---
 rtl/aes_round_key_sched.sv | 183 ++++++++++++++++++
 tb/tb_aes_round_key_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_key_sched.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_key_sched
// Description : Iterative AES-128 key-schedule controller. Accepts a cipher
//               key over a valid/ready handshake and expands one round key
//               per clock using a single SubWord/RotWord/Rcon step. All 11
//               round keys are held and served through an indexed read port
//               and a flat bus carrying rounds 1..10.
// Ports       : clk        - rising-edge clock
//               rst        - synchronous active-high reset
//               key_in     - cipher key, byte 0 in bits [127:120]
//               key_valid  - key_in valid
//               key_ready  - block can accept a key (not expanding)
//               busy       - expansion in progress
//               keys_valid - all 11 round keys stored and stable
//               rk_idx     - read-port round-key index 0..10
//               rk_out     - round key selected by rk_idx (0 for 11..15)
//               full_keys  - round key r (1..10) on bits [128*(r-1) +: 128]
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_key_sched #(
    parameter int NR     = 10,
    parameter bit RD_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [127:0]    key_in,
    input  logic            key_valid,
    output logic            key_ready,
    output logic            busy,
    output logic            keys_valid,
    input  logic [3:0]      rk_idx,
    output logic [127:0]    rk_out,
    output logic [1279:0]   full_keys
);

    // Only AES-128 is supported; any other round count stops elaboration.
    generate
        if (NR != 10) begin : g_nr_check
            $error("aes_round_key_sched: NR must be 10");
        end
    endgenerate

    localparam logic [3:0] c_last_round = 4'd10;

    // Same forward S-box table as the cipher SubBytes stage.
    localparam logic [7:0] c_sbox [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {c_sbox[w[31:24]], c_sbox[w[23:16]], c_sbox[w[15:8]], c_sbox[w[7:0]]};
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_key_ready;
    logic           r_busy;
    logic           r_keys_valid;
    logic [3:0]     r_round;
    logic [7:0]     r_rcon;
    logic [127:0]   r_keys [0:10];

    logic [3:0]     w_src_idx;
    logic [127:0]   w_prev;
    logic [31:0]    w_temp;
    logic [127:0]   w_next;
    logic [127:0]   w_rd_sel;

    // One FIPS-197 round step: new key r derived from stored key r-1.
    always_comb begin
        w_src_idx = r_round - 4'd1;
        w_prev    = r_keys[w_src_idx];
        // RotWord of w3 then SubWord, with rcon folded into the top byte.
        w_temp    = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
        w_next[127:96] = w_prev[127:96] ^ w_temp;
        w_next[95:64]  = w_prev[95:64]  ^ w_next[127:96];
        w_next[63:32]  = w_prev[63:32]  ^ w_next[95:64];
        w_next[31:0]   = w_prev[31:0]   ^ w_next[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_key_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b0;
            r_round      <= 4'd0;
            r_rcon       <= 8'h01;
            for (int i = 0; i <= 10; i++) begin
                r_keys[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (key_valid) begin
                        r_keys[0]    <= key_in;
                        r_keys_valid <= 1'b0;
                        r_round      <= 4'd1;
                        r_rcon       <= 8'h01;
                        r_state      <= ST_EXPAND;
                        r_busy       <= 1'b1;
                        r_key_ready  <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    r_keys[r_round] <= w_next;
                    // xtime: multiply by x in GF(2^8).
                    r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                    if (r_round == c_last_round) begin
                        r_state      <= ST_DONE;
                        r_busy       <= 1'b0;
                        r_key_ready  <= 1'b1;
                        r_keys_valid <= 1'b1;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_key_ready <= 1'b1;
                end
            endcase
        end
    end

    assign key_ready  = r_key_ready;
    assign busy       = r_busy;
    assign keys_valid = r_keys_valid;

    always_comb begin
        w_rd_sel = '0;
        if (rk_idx <= c_last_round) begin
            w_rd_sel = r_keys[rk_idx];
        end
    end

    generate
        if (RD_REG) begin : g_rd_reg
            logic [127:0] r_rk_out;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rk_out <= '0;
                end else begin
                    r_rk_out <= w_rd_sel;
                end
            end
            assign rk_out = r_rk_out;
        end else begin : g_rd_comb
            assign rk_out = w_rd_sel;
        end
    endgenerate

    // Round key 0 is deliberately absent from the flat bus.
    generate
        for (genvar r = 1; r <= 10; r++) begin : g_full
            assign full_keys[128*(r-1) +: 128] = r_keys[r];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_aes_round_key_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_key_sched
// Description : Self-checking bench for aes_round_key_sched. A behavioural
//               key-expansion model (S-box computed from the GF(2^8) inverse
//               and affine map) supplies expected values for directed and
//               random keys. A second instance covers the combinational read
//               port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_key_sched;

    logic            clk;
    logic            rst;
    logic [127:0]    key_in;
    logic            key_valid;
    logic [3:0]      rk_idx;
    logic            key_ready;
    logic            busy;
    logic            keys_valid;
    logic [127:0]    rk_out;
    logic [1279:0]   full_keys;
    logic            c_key_ready;
    logic            c_busy;
    logic            c_keys_valid;
    logic [127:0]    c_rk_out;
    logic [1279:0]   c_full_keys;

    int vectors;
    int miscompares;

    logic [127:0]  exp_keys [0:10];
    logic [1279:0] exp_full;

    localparam logic [127:0] c_fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_round_key_sched #(.NR(10), .RD_REG(1'b1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .full_keys  (full_keys)
    );

    aes_round_key_sched #(.NR(10), .RD_REG(1'b0)) u_dut_comb (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (c_key_ready),
        .busy       (c_busy),
        .keys_valid (c_keys_valid),
        .rk_idx     (rk_idx),
        .rk_out     (c_rk_out),
        .full_keys  (c_full_keys)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);   // x^254 = x^-1, 0 -> 0
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    task automatic model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int r = 1; r <= 10; r++) exp_full[128*(r-1) +: 128] = exp_keys[r];
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [1279:0] obs, input logic [1279:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        check("accept_ready", 1280'(key_ready), 1280'(1));
        step();
        key_valid = 1'b0;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // n0 = cycles since accept at entry; returns cycle count when keys_valid seen.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!keys_valid && n < 20) begin
            step();
            n++;
        end
        check("keys_valid_seen", 1280'(keys_valid), 1280'(1));
    endtask

    task automatic check_idle_after_rst();
        check("rst_key_ready",  1280'(key_ready),  1280'(1));
        check("rst_busy",       1280'(busy),       1280'(0));
        check("rst_keys_valid", 1280'(keys_valid), 1280'(0));
        check("rst_full_keys",  full_keys,         1280'(0));
        check("rst_rk_out",     1280'(rk_out),     1280'(0));
    endtask

    int n;
    int nb;
    logic [127:0] k;
    logic [127:0] exp_rd;
    logic [127:0] prev_rd;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        key_valid   = 1'b0;
        key_in      = '0;
        rk_idx      = 4'd0;
        step(); step(); step();
        rst = 1'b0;
        check_idle_after_rst();
        step();
        check("idle_stays_idle", 1280'(busy), 1280'(0));

        // ---- FIPS-197 key: latency and known round keys ----
        model(c_fips_key);
        accept(c_fips_key);
        check("s1_busy_t1",  1280'(busy),       1280'(1));
        check("s1_kv_t1",    1280'(keys_valid), 1280'(0));
        check("s1_ready_t1", 1280'(key_ready),  1280'(0));
        wait_done(1, n);
        check("s1_latency", 1280'(n), 1280'(11));
        check("s1_full", full_keys, exp_full);
        check("s1_round1",  1280'(full_keys[127:0]),     1280'(128'ha0fafe1788542cb123a339392a6c7605));
        check("s1_round10", 1280'(full_keys[1279:1152]), 1280'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        check("s1_busy_done", 1280'(busy), 1280'(0));
        check("comb_full", c_full_keys, exp_full);

        // ---- read sweep: registered port lags rk_idx by one cycle ----
        prev_rd = '0;
        for (int i = 0; i < 16; i++) begin
            rk_idx = 4'(i);
            exp_rd = (i <= 10) ? exp_keys[i] : 128'h0;
            #1;
            check("sweep_comb", 1280'(c_rk_out), 1280'(exp_rd));
            if (i > 0) check("sweep_lag", 1280'(rk_out), 1280'(prev_rd));
            step();
            check("sweep_reg", 1280'(rk_out), 1280'(exp_rd));
            prev_rd = exp_rd;
        end

        // ---- restart from DONE with the zero key ----
        model(128'h0);
        accept(128'h0);
        check("s6_kv_drop", 1280'(keys_valid), 1280'(0));
        nb = 0;
        while (busy && nb < 20) begin
            nb++;
            step();
        end
        check("s6_busy_cycles", 1280'(nb), 1280'(10));
        check("s6_kv_back", 1280'(keys_valid), 1280'(1));
        check("s6_full", full_keys, exp_full);
        check("s2_round1",  1280'(full_keys[127:0]),     1280'(128'h62636363626363636263636362636363));
        check("s2_round10", 1280'(full_keys[1279:1152]), 1280'(128'hb4ef5bcb3e92e21123e951cf6f8f188e));

        // ---- key_valid while busy is ignored ----
        model(c_fips_key);
        accept(c_fips_key);
        step(); step(); step();              // now in cycle T+4
        key_valid = 1'b1;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        check("s4_ready_busy", 1280'(key_ready), 1280'(0));
        step();
        key_valid = 1'b0;
        wait_done(5, n);
        check("s4_latency", 1280'(n), 1280'(11));
        check("s4_full", full_keys, exp_full);

        // ---- reset in the middle of an expansion ----
        rk_idx = 4'd3;
        accept(c_fips_key);
        step(); step(); step(); step();      // now in cycle T+5
        rst       = 1'b1;
        key_valid = 1'b1;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        step();
        rst       = 1'b0;
        key_valid = 1'b0;
        check_idle_after_rst();
        step();
        check("s5_not_accepted", 1280'(busy), 1280'(0));
        check("s5_storage_zero", 1280'(rk_out), 1280'(0));
        model(c_fips_key);
        accept(c_fips_key);
        wait_done(1, n);
        check("s5_latency", 1280'(n), 1280'(11));
        check("s5_full", full_keys, exp_full);

        // ---- random keys ----
        for (int t = 0; t < 5; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model(k);
            accept(k);
            wait_done(1, n);
            check("rnd_latency", 1280'(n), 1280'(11));
            check("rnd_full", full_keys, exp_full);
            for (int j = 0; j < 3; j++) begin
                rk_idx = 4'($urandom_range(0, 15));
                exp_rd = (rk_idx <= 4'd10) ? exp_keys[rk_idx] : 128'h0;
                #1;
                check("rnd_comb_rd", 1280'(c_rk_out), 1280'(exp_rd));
                step();
                check("rnd_reg_rd", 1280'(rk_out), 1280'(exp_rd));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
